// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: drains a standard (non-FWFT) FIFO read port
// and serialises each byte LSB-first with configurable data bits, parity and
// stop bits. Everything runs on clk using a baud-tick counter.
module uart_tx_param #(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD_RATE = 9600,
  parameter int unsigned BAUD_DIV  = CLK_FREQ / BAUD_RATE,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned DIV_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 txEnable,
  output logic                 readEn,
  input  logic [DATA_BITS-1:0] dout,
  input  logic                 empty,
  output logic                 txData,
  output logic                 busy,
  output logic                 frameDone
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] START = 3'd2;
  localparam logic [2:0] DATA  = 3'd3;
  localparam logic [2:0] PAR   = 3'd4;
  localparam logic [2:0] STOP  = 3'd5;

  localparam int unsigned BIT_W = 4;

  localparam logic [DIV_W-1:0] TICK_VAL     = DIV_W'(BAUD_DIV - 1);
  localparam logic [DIV_W-1:0] PRE_TICK_VAL = DIV_W'(BAUD_DIV - 2);
  localparam logic [BIT_W-1:0] LAST_BIT     = BIT_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP    = 1'(STOP_BITS - 1);
  localparam logic             HAS_PAR      = (PARITY != 0);
  localparam logic             ODD_PAR      = (PARITY == 1);

  logic [2:0]           state,     stateNext;
  logic [DIV_W-1:0]     baudCnt,   baudNext;
  logic [DATA_BITS-1:0] shiftReg,  shiftNext;
  logic [BIT_W-1:0]     bitCnt,    bitNext;
  logic                 parityBit, parityNext;
  logic                 stopCnt,   stopNext;
  logic                 txNext;
  logic                 readNext;
  logic                 busyNext;
  logic                 doneNext;

  logic tick;
  logic preTick;
  logic lastStop;

  // Bit-period boundaries; preTick lets registered outputs land on a bit's final clock
  always_comb begin
    tick     = (baudCnt == TICK_VAL);
    preTick  = (baudCnt == PRE_TICK_VAL);
    lastStop = (stopCnt == LAST_STOP);
  end

  // Next-state and next-output logic
  always_comb begin
    stateNext  = state;
    baudNext   = baudCnt;
    shiftNext  = shiftReg;
    bitNext    = bitCnt;
    parityNext = parityBit;
    stopNext   = stopCnt;
    txNext     = txData;
    readNext   = 1'b0;
    busyNext   = busy;
    doneNext   = 1'b0;

    if (state inside {START, DATA, PAR, STOP}) begin
      baudNext = tick ? '0 : baudCnt + DIV_W'(1);
    end

    case (state)
      IDLE: begin
        txNext   = 1'b1;
        baudNext = '0;
        if (txEnable && !empty) begin
          readNext  = 1'b1;
          busyNext  = 1'b1;
          stateNext = FETCH;
        end
      end
      FETCH: begin
        // dout is valid once the readEn cycle has passed
        baudNext = '0;
        if (!readEn) begin
          shiftNext  = dout;
          parityNext = (^dout) ^ ODD_PAR;
          txNext     = 1'b0;
          stateNext  = START;
        end
      end
      START: begin
        if (tick) begin
          txNext    = shiftReg[0];
          shiftNext = shiftReg >> 1;
          bitNext   = '0;
          stateNext = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          if (bitCnt < LAST_BIT) begin
            txNext    = shiftReg[0];
            shiftNext = shiftReg >> 1;
            bitNext   = bitCnt + BIT_W'(1);
          end else if (HAS_PAR) begin
            txNext    = parityBit;
            stateNext = PAR;
          end else begin
            txNext    = 1'b1;
            stopNext  = 1'b0;
            stateNext = STOP;
          end
        end
      end
      PAR: begin
        if (tick) begin
          txNext    = 1'b1;
          stopNext  = 1'b0;
          stateNext = STOP;
        end
      end
      STOP: begin
        // frameDone and a chained readEn share the final clock of the last stop bit
        if (preTick && lastStop) begin
          doneNext = 1'b1;
          if (txEnable && !empty) begin
            readNext = 1'b1;
          end
        end
        if (tick) begin
          if (lastStop) begin
            if (readEn) begin
              stateNext = FETCH;
            end else begin
              busyNext  = 1'b0;
              stateNext = IDLE;
            end
          end else begin
            stopNext = 1'b1;
          end
        end
      end
      default: begin
        txNext    = 1'b1;
        busyNext  = 1'b0;
        stateNext = IDLE;
      end
    endcase
  end

  // State and output registers; reset parks the line high immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      baudCnt   <= '0;
      shiftReg  <= '0;
      bitCnt    <= '0;
      parityBit <= 1'b0;
      stopCnt   <= 1'b0;
      txData    <= 1'b1;
      readEn    <= 1'b0;
      busy      <= 1'b0;
      frameDone <= 1'b0;
    end else begin
      state     <= stateNext;
      baudCnt   <= baudNext;
      shiftReg  <= shiftNext;
      bitCnt    <= bitNext;
      parityBit <= parityNext;
      stopCnt   <= stopNext;
      txData    <= txNext;
      readEn    <= readNext;
      busy      <= busyNext;
      frameDone <= doneNext;
    end
  end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
- Parametrised UART transmitter; successor to the team's fixed 8N1 transmitter.
- Drains bytes from a standard (non-FWFT) FIFO read port and serialises them LSB-first on txData.
- Frame format is configurable: 5–9 data bits, none/odd/even parity, 1 or 2 stop bits.
- Runs entirely on the system clock using a baud-tick counter; no derived clock. Sits between the TX FIFO and the board TX pin.

Parameters:
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD_RATE, 9600: line rate in baud.
- BAUD_DIV, CLK_FREQ/BAUD_RATE: clocks per bit (integer division). Must be ≥ 4.
- DATA_BITS, 8: data bits per frame, legal range 5–9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- DIV_W, 16: baud counter width. Must satisfy 2^DIV_W > BAUD_DIV.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- txEnable  in  1  when high, new frames may start. A frame in progress always completes.
- readEn  out  1  FIFO read strobe, one-cycle pulse.
- dout  in  DATA_BITS  FIFO read data, valid the cycle after readEn.
- empty  in  1  FIFO empty flag.
- txData  out  1  serial line (idle high).
- busy  out  1  high from the readEn cycle until the end of the last stop bit.
- frameDone  out  1  one-cycle pulse on the final clock of the last stop bit.

Behaviour:
Reset (asynchronous, immediate, including mid-frame):
- txData=1, readEn=0, busy=0, frameDone=0.
- State=IDLE, baud counter=0, shift register=0, bit counter=0.
- The line never glitches low on reset.

Outputs:
- All outputs are registered.
- State holds encoded: IDLE, FETCH, START, DATA, PAR, STOP.

Baud counter:
- Cleared on entry to START.
- Increments every clock in START/DATA/PAR/STOP.
- tick = (count == BAUD_DIV-1); the counter wraps to 0 on tick.
- Each bit therefore lasts exactly BAUD_DIV clocks.

State transitions:
- IDLE: if txEnable && !empty, assert readEn for one cycle, set busy, go to FETCH. Otherwise remain idle with txData=1.
- FETCH (1 clock):
  - Capture dout into the shift register.
  - Compute parity: odd parity = ~^dout[DATA_BITS-1:0]; even parity = ^dout[DATA_BITS-1:0].
  - Drive txData=0, go to START.
- START: on tick, drive txData = shift[0], shift right, bitcount=0, go to DATA.
- DATA:
  - On tick with bitcount < DATA_BITS-1: shift, drive the next bit, increment bitcount.
  - On tick at the last bit with PARITY != 0: drive the parity bit, go to PAR.
  - On tick at the last bit with PARITY == 0: drive 1, go to STOP.
- PAR: on tick, drive 1, go to STOP.
- STOP:
  - Hold txData=1 for STOP_BITS×BAUD_DIV clocks.
  - On the final tick, pulse frameDone.
  - If txEnable && !empty on that same cycle: assert readEn, keep busy, go to FETCH (back-to-back).
  - Otherwise clear busy and go to IDLE.

Timing:
- Back-to-back frames: line is high for STOP_BITS×BAUD_DIV + 1 clocks between the last data/parity bit and the next start bit.
- Latency from empty falling (with txEnable high) in IDLE: readEn on the next edge; txData falls 2 clocks after readEn.

Boundary conditions:
- txEnable dropped mid-frame: no effect on the current frame; it is sampled only in IDLE and at the final STOP tick.
- empty rising while the FIFO is being read: ignored.
- The block never reads while empty=1.
- Exactly one readEn per frame, never two in consecutive cycles.
- dout is sampled only in FETCH; its value at other times is don't-care.
- DATA_BITS=9: dout[8] is transmitted last among the data bits.

Test Plan:
1. Use CLK_FREQ=1_000_000, BAUD_RATE=100_000 (BAUD_DIV=10), 8N1. Push 0xA5 → single readEn pulse; txData low for 10 clocks, then bits 1,0,1,0,0,1,0,1 at 10 clocks each, then high for 10 clocks. frameDone pulses once; busy drops the cycle after.
2. Same configuration with PARITY=2 (even), STOP_BITS=2. Send 0x07 → parity bit 1, stop high for 20 clocks. With PARITY=1 (odd), send 0x07 → parity bit 0.
3. DATA_BITS=5, PARITY=0. Send 0x1F → 5 high data bits, total frame length 70 clocks start-to-stop-end.
4. Load 3 bytes, 0x00, 0xFF, 0x55 → three frames with a 10+1 clock high gap. readEn fires on each frameDone cycle while not empty; the bench FIFO-model checker sees no read on empty.
5. Hold txEnable=0 with the FIFO non-empty → no readEn, txData=1. Raise txEnable → transmission starts. Drop txEnable during the data bits → the frame completes and no further readEn follows.
6. Assert rst at bit 4 of a frame → txData=1, busy=0, readEn=0 in the same cycle (async). After release with the FIFO non-empty, a clean new frame starts from IDLE.
